vid2is_frame_sequencer: RTL

- Controller for the clocked-video-input write path. Sits between the sync-decoded video stream and the write buffer.
- Frames the incoming samples into Avalon-ST Video packets: one control packet, then the image-packet header, then the active samples.
- Drives the buffer's wrreq/data/packet/convert/hd_sdn/early_eop inputs and measures frame geometry for the next control packet.

---
 rtl/vid2is_frame_sequencer_if.sv | 28 ++
 rtl/vid2is_frame_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid2is_frame_sequencer_if.sv
// Video-in / write-buffer signal bundle for the clocked-video-input frame sequencer.
// The sequencer takes the master side; the video source and write buffer take the slave side.
interface vid2is_frame_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 20
);
    logic                  vid_valid;
    logic                  vid_de;
    logic                  vid_v_sync;
    logic                  vid_f;
    logic [DATA_WIDTH-1:0] vid_data;

    logic                  buf_wrreq;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_packet;
    logic                  buf_convert;
    logic                  buf_hd_sdn;
    logic                  buf_early_eop;

    modport master (
        input  vid_valid, vid_de, vid_v_sync, vid_f, vid_data,
        output buf_wrreq, buf_data, buf_packet, buf_convert, buf_hd_sdn, buf_early_eop
    );

    modport slave (
        output vid_valid, vid_de, vid_v_sync, vid_f, vid_data,
        input  buf_wrreq, buf_data, buf_packet, buf_convert, buf_hd_sdn, buf_early_eop
    );
endinterface

// File: rtl/vid2is_frame_sequencer.sv
// Frames sync-decoded video into Avalon-ST Video packets (control packet, image header, samples)
// and measures field geometry for the next control packet. Buffer-side outputs are registered.
module vid2is_frame_sequencer #(
    parameter int unsigned DATA_WIDTH     = 20,
    parameter int unsigned BPS            = 10,
    parameter int unsigned DEFAULT_WIDTH  = 720,
    parameter int unsigned DEFAULT_HEIGHT = 240
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            hd_sdn_cfg,
    vid2is_frame_sequencer_if.master        bus,
    output logic [15:0]                     meas_width,
    output logic [15:0]                     meas_height,
    output logic                            abort_sticky
);

    localparam int unsigned NibW = (BPS < 4) ? BPS : 4;
    localparam logic [15:0] DefWidth  = 16'(DEFAULT_WIDTH);
    localparam logic [15:0] DefHeight = 16'(DEFAULT_HEIGHT);

    typedef enum logic [2:0] {
        StIdle,
        StWaitSof,
        StCtrlHdr,
        StCtrlBody,
        StImgHdr,
        StActive,
        StFlush
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            body_cnt_q, body_cnt_d;
    logic                  vsync_q;
    logic                  de_q, de_d;
    logic                  f_latched_q, f_latched_d;
    logic                  f_prev_q, f_prev_d;
    logic                  f_seen_q, f_seen_d;
    logic                  f_hist_q, f_hist_d;
    logic                  hd_sdn_q, hd_sdn_d;
    logic                  latch_mode;
    logic [15:0]           sym_cnt_q, sym_cnt_d;
    logic [15:0]           line_cnt_q, line_cnt_d;
    logic [15:0]           line_width_q, line_width_d;
    logic                  par_q, par_d;
    logic [15:0]           meas_width_q, meas_width_d;
    logic [15:0]           meas_height_q, meas_height_d;
    logic                  abort_q, abort_d;
    logic                  wrreq_q, wrreq_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  packet_q, packet_d;
    logic                  eop_q, eop_d;

    logic                  vs_rise;
    logic                  sample;
    logic                  in_hdr;
    logic                  accept;
    logic                  de_fall;
    logic                  intl;
    logic [3:0]            nib;

    function automatic logic [DATA_WIDTH-1:0] hdr_word(input logic [3:0] n);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        w[NibW-1:0] = n[NibW-1:0];
        return w;
    endfunction

    assign vs_rise = bus.vid_v_sync & ~vsync_q;
    assign sample  = bus.vid_valid & bus.vid_de;
    assign in_hdr  = (state_q == StCtrlHdr) | (state_q == StCtrlBody) | (state_q == StImgHdr);
    // The sample coinciding with the field-start edge belongs to no frame and is dropped.
    assign accept  = (state_q == StActive) & sample & ~vs_rise;
    assign de_fall = (state_q == StActive) & de_q & ~bus.vid_de;
    assign intl    = f_hist_q & (f_latched_q ^ f_prev_q);

    // FSM next state
    always_comb begin
        state_d    = state_q;
        body_cnt_d = body_cnt_q;
        latch_mode = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable) state_d = StWaitSof;
            end
            StWaitSof: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (vs_rise) begin
                    state_d    = StCtrlHdr;
                    latch_mode = 1'b1;
                end
            end
            StCtrlHdr: begin
                state_d    = StCtrlBody;
                body_cnt_d = 4'd0;
            end
            StCtrlBody: begin
                if (body_cnt_q == 4'd8) state_d = StImgHdr;
                else                    body_cnt_d = body_cnt_q + 4'd1;
            end
            StImgHdr: begin
                state_d = StActive;
            end
            StActive: begin
                if (vs_rise) state_d = StFlush;
            end
            StFlush: begin
                if (enable) begin
                    state_d    = StCtrlHdr;
                    latch_mode = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control-packet nibble sequence: width, height, interlace
    always_comb begin
        nib = 4'h0;
        case (body_cnt_q)
            4'd0:    nib = meas_width_q[15:12];
            4'd1:    nib = meas_width_q[11:8];
            4'd2:    nib = meas_width_q[7:4];
            4'd3:    nib = meas_width_q[3:0];
            4'd4:    nib = meas_height_q[15:12];
            4'd5:    nib = meas_height_q[11:8];
            4'd6:    nib = meas_height_q[7:4];
            4'd7:    nib = meas_height_q[3:0];
            4'd8:    nib = {intl, f_latched_q, 2'b00};
            default: nib = 4'h0;
        endcase
    end

    // Buffer-side outputs, registered below
    always_comb begin
        wrreq_d  = 1'b0;
        data_d   = '0;
        packet_d = 1'b0;
        eop_d    = 1'b0;
        case (state_q)
            StCtrlHdr: begin
                wrreq_d  = 1'b1;
                data_d   = hdr_word(4'hF);
                packet_d = 1'b1;
            end
            StCtrlBody: begin
                wrreq_d = 1'b1;
                data_d  = hdr_word(nib);
            end
            StImgHdr: begin
                wrreq_d  = 1'b1;
                data_d   = hdr_word(4'h0);
                packet_d = 1'b1;
            end
            StActive: begin
                wrreq_d = accept;
                data_d  = bus.vid_data;
            end
            StFlush: begin
                // A lone SD symbol is still half-packed in the buffer and must be pushed out.
                eop_d = ~hd_sdn_q & par_q;
            end
            default: ;
        endcase
    end

    // Geometry measurement, field history, mode latch and abort flag
    always_comb begin
        sym_cnt_d     = sym_cnt_q;
        line_cnt_d    = line_cnt_q;
        line_width_d  = line_width_q;
        par_d         = par_q;
        meas_width_d  = meas_width_q;
        meas_height_d = meas_height_q;
        f_latched_d   = f_latched_q;
        f_prev_d      = f_prev_q;
        f_seen_d      = f_seen_q;
        f_hist_d      = f_hist_q;
        hd_sdn_d      = latch_mode ? hd_sdn_cfg : hd_sdn_q;
        abort_d       = abort_q | (in_hdr & sample);
        de_d          = (state_q == StActive) & bus.vid_de;

        if (state_q == StFlush) begin
            if (line_cnt_q != 16'd0) begin
                meas_width_d  = line_width_q;
                meas_height_d = line_cnt_q;
            end
            line_cnt_d = 16'd0;
            sym_cnt_d  = 16'd0;
            par_d      = 1'b0;
        end else begin
            if (accept) begin
                sym_cnt_d = (sym_cnt_q == 16'hFFFF) ? sym_cnt_q : sym_cnt_q + 16'd1;
                par_d     = ~par_q;
            end
            if (de_fall) begin
                line_cnt_d   = (line_cnt_q == 16'hFFFF) ? line_cnt_q : line_cnt_q + 16'd1;
                line_width_d = hd_sdn_q ? sym_cnt_q : (sym_cnt_q >> 1);
                sym_cnt_d    = 16'd0;
            end
        end

        if (vs_rise) begin
            f_prev_d    = f_latched_q;
            f_latched_d = bus.vid_f;
            f_hist_d    = f_seen_q;
            f_seen_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            body_cnt_q    <= 4'd0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            f_latched_q   <= 1'b0;
            f_prev_q      <= 1'b0;
            f_seen_q      <= 1'b0;
            f_hist_q      <= 1'b0;
            hd_sdn_q      <= 1'b0;
            sym_cnt_q     <= 16'd0;
            line_cnt_q    <= 16'd0;
            line_width_q  <= 16'd0;
            par_q         <= 1'b0;
            meas_width_q  <= DefWidth;
            meas_height_q <= DefHeight;
            abort_q       <= 1'b0;
            wrreq_q       <= 1'b0;
            data_q        <= '0;
            packet_q      <= 1'b0;
            eop_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            body_cnt_q    <= body_cnt_d;
            vsync_q       <= bus.vid_v_sync;
            de_q          <= de_d;
            f_latched_q   <= f_latched_d;
            f_prev_q      <= f_prev_d;
            f_seen_q      <= f_seen_d;
            f_hist_q      <= f_hist_d;
            hd_sdn_q      <= hd_sdn_d;
            sym_cnt_q     <= sym_cnt_d;
            line_cnt_q    <= line_cnt_d;
            line_width_q  <= line_width_d;
            par_q         <= par_d;
            meas_width_q  <= meas_width_d;
            meas_height_q <= meas_height_d;
            abort_q       <= abort_d;
            wrreq_q       <= wrreq_d;
            data_q        <= data_d;
            packet_q      <= packet_d;
            eop_q         <= eop_d;
        end
    end

    assign bus.buf_wrreq     = wrreq_q;
    assign bus.buf_data      = data_q;
    assign bus.buf_packet    = packet_q;
    assign bus.buf_early_eop = eop_q;
    assign bus.buf_hd_sdn    = hd_sdn_q;
    assign bus.buf_convert   = (state_q != StIdle) & ~hd_sdn_q;
    assign meas_width        = meas_width_q;
    assign meas_height       = meas_height_q;
    assign abort_sticky      = abort_q;

endmodule
